// File: rtl/pma_lock_seq.sv
// Purpose: PLL/PMA lock sequencer: pulses the PLL reset, waits for lock, and releases the PMA once lock is stable.
// Latency: pll_locked is seen 2 cycles late (synchroniser); all outputs are registered (1 cycle after a decision).
// Backpressure: none; restart is a single-cycle request that is always accepted on the next edge.
//
// Ports:
//   clk_in      free-running reference clock, the only clock
//   reset_n     asynchronous active-low reset
//   pll_locked  PLL lock flag, asynchronous to clk_in
//   restart     synchronous single-cycle request to restart the sequence
//   pll_reset   active-high reset to the PLL (high in PRST and FAULT)
//   pma_reset   active-high reset to downstream PMA logic (low only in READY)
//   ready       sequence complete and lock stable
//   fault       lock retries exhausted; held until restart or reset_n
//   retry_count lock timeouts since the last entry to READY

module pma_lock_seq #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_reset,
    output logic       pma_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    // Terminal counts, expressed as the last counter value spent in a state.
    localparam logic [19:0] RST_LAST  = 20'(RESET_CYCLES - 1);
    localparam logic [19:0] TO_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STAB_LAST = 20'(LOCK_STABLE - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PRST  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STAB  = 3'd2,
        ST_READY = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [19:0] cnt_inc;
    logic [3:0]  retry_nxt;
    logic        lk_meta;
    logic        lk_s;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous lock flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // One shared counter serves the reset pulse, the lock timeout and the
    // stability window; every state change reloads it with zero, so each
    // state starts its own count. It holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == 20'hFFFFF) ? cnt : cnt + 20'd1;

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        retry_nxt = retry_count;

        if (restart) begin
            // Restart overrides every other transition, including FAULT hold.
            state_nxt = ST_PRST;
            cnt_nxt   = 20'd0;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                ST_PRST: begin
                    if (cnt >= RST_LAST) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 20'd0;
                    end
                end

                ST_WAIT: begin
                    if (lk_s) begin
                        state_nxt = ST_STAB;
                        cnt_nxt   = 20'd0;
                    end else if (cnt >= TO_LAST) begin
                        cnt_nxt = 20'd0;
                        if (retry_count < RETRY_MAX) begin
                            retry_nxt = retry_count + 4'd1;
                            state_nxt = ST_PRST;
                        end else begin
                            // Out of retries: the count stays at its maximum
                            // so software can see how far the sequence got.
                            state_nxt = ST_FAULT;
                        end
                    end
                end

                ST_STAB: begin
                    if (!lk_s) begin
                        // A lock drop here is a glitch, not a timeout: go
                        // back to waiting without charging a retry.
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 20'd0;
                    end else if (cnt >= STAB_LAST) begin
                        state_nxt = ST_READY;
                        cnt_nxt   = 20'd0;
                        retry_nxt = 4'd0;
                    end
                end

                ST_READY: begin
                    cnt_nxt = 20'd0;
                    if (!lk_s) begin
                        state_nxt = ST_PRST;
                    end
                end

                ST_FAULT: begin
                    cnt_nxt = 20'd0;
                end

                default: begin
                    state_nxt = ST_PRST;
                    cnt_nxt   = 20'd0;
                    retry_nxt = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PRST;
            cnt         <= 20'd0;
            retry_count <= 4'd0;
            pll_reset   <= 1'b1;
            pma_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_reset   <= (state_nxt == ST_PRST) || (state_nxt == ST_FAULT);
            pma_reset   <= (state_nxt != ST_READY);
            ready       <= (state_nxt == ST_READY);
            fault       <= (state_nxt == ST_FAULT);
        end
    end

endmodule
